// File: rtl/constellation_hist.sv
// I/Q constellation density histogram: biases signed samples, bins in-window hits
// into saturating counters over a frame, then streams bins out with clear-on-read.
module constellation_hist #(
  parameter int IN_W      = 4,
  parameter int GRID      = 4,
  parameter int CNT_W     = 9,
  parameter int FRAME_LEN = 256,
  localparam int NB       = GRID * GRID,
  localparam int IDX_W    = (NB > 1) ? $clog2(NB) : 1,
  localparam int FC_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IN_W-1:0]  win_x,
  input  logic [IN_W-1:0]  win_y,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_i,
  input  logic [IN_W-1:0]  in_q,
  output logic             busy,
  output logic             frame_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic [FC_W-1:0]  hit_cnt,
  output logic [FC_W-1:0]  miss_cnt,
  output logic             sat_flag
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, READ} state_t;

  localparam logic [IN_W-1:0] BIAS   = IN_W'(1) << (IN_W - 1);
  localparam logic [IN_W:0]   GRID_L = (IN_W + 1)'(GRID);

  state_t                      state;
  logic [IN_W-1:0]             win_x_r, win_y_r, u_i, u_q;
  logic [IN_W:0]               dx, dy;
  logic                        hit_c, accept, xfer;
  logic [IDX_W-1:0]            bin_c;
  logic [FC_W-1:0]             frm_cnt;
  logic                        s1_vld, s1_hit;
  logic [IDX_W-1:0]            s1_bin;
  logic [NB-1:0]               inc_vec, clr_vec, sat_vec;
  logic [NB-1:0][CNT_W-1:0]    cnt_vec;

  // Adding 2^(IN_W-1) modulo 2^IN_W is just an MSB flip.
  assign u_i    = in_i ^ BIAS;
  assign u_q    = in_q ^ BIAS;
  assign dx     = {1'b0, u_i} - {1'b0, win_x_r};
  assign dy     = {1'b0, u_q} - {1'b0, win_y_r};
  assign hit_c  = !dx[IN_W] && !dy[IN_W] && (dx < GRID_L) && (dy < GRID_L);
  assign bin_c  = IDX_W'(dy[IN_W-1:0]) * IDX_W'(GRID) + IDX_W'(dx[IN_W-1:0]);
  assign accept = (state == ACCUM) && in_valid;

  assign busy      = (state != IDLE);
  assign out_valid = (state == READ);
  assign xfer      = out_valid && out_ready;
  assign out_last  = out_valid && (out_idx == IDX_W'(NB - 1));
  assign out_data  = cnt_vec[out_idx];

  for (genvar g = 0; g < NB; g++) begin : g_bin
    assign inc_vec[g] = s1_vld && s1_hit && (s1_bin == IDX_W'(g));
    assign clr_vec[g] = xfer && (out_idx == IDX_W'(g));
    constellation_bin #(.CNT_W(CNT_W)) u_bin (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (inc_vec[g]),
      .clr   (clr_vec[g]),
      .cnt   (cnt_vec[g]),
      .sat   (sat_vec[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      win_x_r    <= '0;
      win_y_r    <= '0;
      frm_cnt    <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      sat_flag   <= 1'b0;
      frame_done <= 1'b0;
      out_idx    <= '0;
      s1_vld     <= 1'b0;
      s1_hit     <= 1'b0;
      s1_bin     <= '0;
    end else begin
      frame_done <= 1'b0;
      s1_vld     <= accept;
      s1_hit     <= hit_c;
      s1_bin     <= bin_c;
      // Stage 2 statistics; never overlaps the IDLE clear below.
      if (s1_vld) begin
        if (s1_hit) hit_cnt  <= hit_cnt + FC_W'(1);
        else        miss_cnt <= miss_cnt + FC_W'(1);
      end
      if (|sat_vec) sat_flag <= 1'b1;
      case (state)
        IDLE: if (start) begin
          win_x_r  <= win_x;
          win_y_r  <= win_y;
          frm_cnt  <= '0;
          hit_cnt  <= '0;
          miss_cnt <= '0;
          sat_flag <= 1'b0;
          state    <= ACCUM;
        end
        ACCUM: if (in_valid) begin
          frm_cnt <= frm_cnt + FC_W'(1);
          if (frm_cnt == FC_W'(FRAME_LEN - 1)) state <= DRAIN;
        end
        DRAIN: begin
          state      <= READ;
          frame_done <= 1'b1;
          out_idx    <= '0;
        end
        READ: if (xfer) begin
          if (out_last) begin
            state   <= IDLE;
            out_idx <= '0;
          end else begin
            out_idx <= out_idx + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// One saturating histogram bin; sat flags a hit that was absorbed at full scale.
module constellation_bin #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);
  localparam logic [CNT_W-1:0] MAX = '1;

  assign sat = inc && (cnt == MAX);

  always_ff @(posedge clk) begin
    if (!rst_n || clr)            cnt <= '0;
    else if (inc && cnt != MAX)   cnt <= cnt + CNT_W'(1);
  end
endmodule

// File: doc/constellation_hist.md
Name: constellation_hist

Overview:
- Parametrised I/Q constellation density histogram for the SDR receive path.
- Takes signed I/Q samples, biases them to unsigned, and bins hits inside a runtime-programmable GRID x GRID window into saturating counters.
- Runs over a fixed-length frame, then streams the bins out over a valid/ready handshake with clear-on-read.
- Successor to the fixed-window matrix accumulator; adds a runtime window origin, frame control, saturation, hit/miss statistics and a streamed readout.

Parameters:
IN_W, 4, width of signed in_i/in_q
GRID, 4, bins per axis; GRID*GRID counters total
CNT_W, 9, width of each bin counter
FRAME_LEN, 256, accepted samples per frame (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  pulse; begins a frame when IDLE, ignored otherwise
win_x  input  IN_W  unsigned biased I origin; sampled on accepted start
win_y  input  IN_W  unsigned biased Q origin; sampled on accepted start
in_valid  input  1  sample qualifier
in_i  input  IN_W  signed I sample
in_q  input  IN_W  signed Q sample
busy  output  1  high in every state except IDLE
frame_done  output  1  one-cycle pulse on entry to READ
out_valid  output  1  bin word valid
out_ready  input  1  consumer accepts bin word
out_data  output  CNT_W  count of bin out_idx
out_idx  output  clog2(GRID*GRID)  bin index, row-major: y*GRID+x
out_last  output  1  out_valid and out_idx==GRID*GRID-1
hit_cnt  output  clog2(FRAME_LEN+1)  in-window samples this frame
miss_cnt  output  clog2(FRAME_LEN+1)  out-of-window samples this frame
sat_flag  output  1  sticky; some bin saturated this frame

Behaviour:
- Reset (rst_n low at a clock edge):
  - State -> IDLE.
  - All bins, hit_cnt, miss_cnt, sat_flag, the frame counter and out_idx -> 0.
  - busy, frame_done, out_valid -> 0. Window registers -> 0.
  - Reset in any state aborts the frame with no partial output.
- Bias and binning:
  - u_i = in_i + 2^(IN_W-1) and u_q = in_q + 2^(IN_W-1), unsigned, range 0..2^IN_W-1.
  - x = u_i - win_x, y = u_q - win_y, computed at IN_W+1 bits signed.
  - Hit iff 0<=x<GRID and 0<=y<GRID; anything else is a miss.
  - A window extending past 2^IN_W-1 is legal; the unreachable bins stay 0.
- States: IDLE, ACCUM, DRAIN, READ.
  - IDLE: start=1 latches win_x/win_y, clears the frame counter, hit_cnt, miss_cnt and sat_flag, then -> ACCUM.
  - ACCUM: a sample is accepted when in_valid=1. Each accepted sample increments the frame counter.
    - Stage 1 registers the sample and its hit/miss decision at edge t.
    - Stage 2 updates the bin and hit_cnt or miss_cnt at edge t+1.
    - When the FRAME_LEN-th sample is accepted -> DRAIN.
  - DRAIN: exactly one cycle, so the last sample's stage-2 update lands. in_valid is ignored. Then -> READ.
  - READ:
    - frame_done pulses in the first cycle. out_valid=1 with out_idx starting at 0.
    - out_data is the bin value, combinationally muxed by out_idx.
    - Transfer = out_valid && out_ready. On transfer the bin is cleared to 0 and out_idx increments.
    - Without out_ready, out_idx and out_data hold stable.
    - Transfer with out_last -> IDLE, out_valid=0, out_idx=0.
- Outside ACCUM, in_valid is ignored and samples are dropped uncounted.
- Saturation: a bin at 2^CNT_W-1 stays there on a further hit and sets sat_flag. hit_cnt is still incremented.
- hit_cnt + miss_cnt == FRAME_LEN at frame_done. Both hold their values until the next accepted start.
- start in ACCUM, DRAIN or READ has no effect. start and in_valid together in IDLE: that sample is not accepted; accumulation starts the next cycle.

Test Plan:
- Reset: after rst_n low, busy=0, out_valid=0, hit_cnt=0, miss_cnt=0, sat_flag=0. After a full frame, reset mid-READ -> IDLE, and all 16 bins read 0 on the next frame with zero hits.
- Binning, defaults with FRAME_LEN=3, win_x=win_y=7 (covers signed -1..2): samples (0,0), (-1,2), (3,0) -> frame_done. Readout bin5=1, bin12=1, all other bins 0. hit_cnt=2, miss_cnt=1, out_last on idx 15.
- Back-pressure: same frame with out_ready toggling 1,0,0,1,...; out_idx/out_data stable while stalled; exactly 16 transfers. A second frame starting right after reads all bins cleared except that frame's new hits.
- Saturation, FRAME_LEN=600: 600x sample (0,0) -> bin5=511, sat_flag=1, hit_cnt=600, miss_cnt=0.
- Gaps and ignored inputs: in_valid 50% duty, FRAME_LEN=8 -> frame_done only after the 8th valid sample. start pulsed during ACCUM and READ does not restart the frame. in_valid during DRAIN/READ is not counted.
- Window edge: win_x=14, win_y=0, sample (7,-8) -> u=(15,0), x=1, y=0 -> bin1=1. Sample (-8,-8) -> miss.
